// File: rtl/next_address_control.sv
// Am29811-style next-address controller: pipelines the next-address fields of each microword,
// evaluates the selected test condition, and drives the 4-bit sequencer slice controls.
module next_address_control #(
  parameter int AW = 12,
  parameter int CW = 12
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [3:0]    uop,
  input  logic [AW-1:0] uba,
  input  logic [2:0]    cc_sel,
  input  logic          cc_pol,
  input  logic [7:0]    cc_vec,
  input  logic [AW-1:0] map_addr,
  input  logic [AW-1:0] vect_addr,
  input  logic          hold,
  output logic          s1,
  output logic          s0,
  output logic          fe,
  output logic          pup,
  output logic          re,
  output logic          zero,
  output logic          cin,
  output logic [AW-1:0] d_out,
  output logic          ctr_zero,
  output logic          stk_err
);

  typedef enum logic [3:0] {
    OP_JZ   = 4'd0,  OP_CJS  = 4'd1,  OP_JMAP = 4'd2,  OP_CJP  = 4'd3,
    OP_PUSH = 4'd4,  OP_JSRP = 4'd5,  OP_CJV  = 4'd6,  OP_JRP  = 4'd7,
    OP_RFCT = 4'd8,  OP_RPCT = 4'd9,  OP_CRTN = 4'd10, OP_CJPP = 4'd11,
    OP_LDCT = 4'd12, OP_LOOP = 4'd13, OP_CONT = 4'd14, OP_TWB  = 4'd15
  } op_e;

  localparam logic [1:0] SRC_PC = 2'b00;
  localparam logic [1:0] SRC_AR = 2'b01;
  localparam logic [1:0] SRC_ST = 2'b10;
  localparam logic [1:0] SRC_D  = 2'b11;
  localparam logic [2:0] DEPTH_MAX = 3'd4;

  op_e           op_r;
  logic [AW-1:0] ba_r;
  logic [2:0]    sel_r;
  logic          pol_r;
  logic [CW-1:0] ctr_r;
  logic [2:0]    depth_r;
  logic          stk_err_r;

  logic          pass_s;
  logic          ctr_nz_s;
  logic [1:0]    src_s;
  logic          push_s;
  logic          pop_s;
  logic          load_s;
  logic          dec_s;
  logic          clr_depth_s;

  assign pass_s   = cc_vec[sel_r] ^ pol_r;
  assign ctr_nz_s = (ctr_r != {CW{1'b0}});
  assign ctr_zero = ~ctr_nz_s;
  assign stk_err  = stk_err_r;
  assign s1       = src_s[1];
  assign s0       = src_s[0];

  // Opcode decode: source select, stack/counter actions and slice controls
  always_comb begin
    src_s       = SRC_PC;
    fe          = 1'b1;
    pup         = 1'b0;
    re          = 1'b1;
    zero        = 1'b1;
    cin         = 1'b1;
    d_out       = ba_r;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    load_s      = 1'b0;
    dec_s       = 1'b0;
    clr_depth_s = 1'b0;
    case (op_r)
      OP_JZ:   begin zero = 1'b0; clr_depth_s = 1'b1; end
      OP_CJS:  if (pass_s) begin src_s = SRC_D; push_s = 1'b1; end else begin src_s = SRC_PC; end
      OP_JMAP: begin src_s = SRC_D; d_out = map_addr; end
      OP_CJP:  src_s = pass_s ? SRC_D : SRC_PC;
      OP_PUSH: begin push_s = 1'b1; load_s = pass_s; end
      OP_JSRP: begin src_s = pass_s ? SRC_D : SRC_AR; push_s = 1'b1; end
      OP_CJV:  if (pass_s) begin src_s = SRC_D; d_out = vect_addr; end else begin src_s = SRC_PC; end
      OP_JRP:  src_s = pass_s ? SRC_D : SRC_AR;
      OP_RFCT: if (ctr_nz_s) begin src_s = SRC_ST; dec_s = 1'b1; end else begin pop_s = 1'b1; end
      OP_RPCT: if (ctr_nz_s) begin src_s = SRC_D; dec_s = 1'b1; end else begin src_s = SRC_PC; end
      OP_CRTN: if (pass_s) begin src_s = SRC_ST; pop_s = 1'b1; end else begin src_s = SRC_PC; end
      OP_CJPP: if (pass_s) begin src_s = SRC_D; pop_s = 1'b1; end else begin src_s = SRC_PC; end
      OP_LDCT: load_s = 1'b1;
      OP_LOOP: if (pass_s) begin pop_s = 1'b1; end else begin src_s = SRC_ST; end
      OP_CONT: src_s = SRC_PC;
      OP_TWB: begin
        if (pass_s) begin
          pop_s = 1'b1;
        end else if (ctr_nz_s) begin
          src_s = SRC_ST;
          dec_s = 1'b1;
        end else begin
          src_s = SRC_D;
          pop_s = 1'b1;
        end
      end
      default: src_s = SRC_PC;
    endcase
    if (push_s || pop_s) begin
      fe  = 1'b0;
      pup = push_s;
    end else begin
      fe  = 1'b1;
    end
    re = ~load_s;
    // A stall re-fetches the current PC and must leave every piece of state untouched
    if (hold) begin
      src_s       = SRC_PC;
      fe          = 1'b1;
      pup         = 1'b0;
      re          = 1'b1;
      zero        = 1'b1;
      cin         = 1'b0;
      push_s      = 1'b0;
      pop_s       = 1'b0;
      load_s      = 1'b0;
      dec_s       = 1'b0;
      clr_depth_s = 1'b0;
    end else begin
      cin         = 1'b1;
    end
  end

  // Microword pipeline register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_r  <= OP_JZ;
      ba_r  <= {AW{1'b0}};
      sel_r <= 3'd0;
      pol_r <= 1'b0;
    end else if (!hold) begin
      op_r  <= op_e'(uop);
      ba_r  <= uba;
      sel_r <= cc_sel;
      pol_r <= cc_pol;
    end
  end

  // Loop counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctr_r <= {CW{1'b0}};
    end else if (load_s) begin
      ctr_r <= ba_r[CW-1:0];
    end else if (dec_s) begin
      ctr_r <= ctr_r - CW'(1'b1);
    end
  end

  // Stack depth tracker with sticky overflow/underflow flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      depth_r   <= 3'd0;
      stk_err_r <= 1'b0;
    end else if (clr_depth_s) begin
      depth_r <= 3'd0;
    end else if (push_s) begin
      if (depth_r == DEPTH_MAX) stk_err_r <= 1'b1;
      else                      depth_r   <= depth_r + 3'd1;
    end else if (pop_s) begin
      if (depth_r == 3'd0) stk_err_r <= 1'b1;
      else                 depth_r   <= depth_r - 3'd1;
    end
  end

endmodule

// File: tb/tb_next_address_control.sv
// Directed, table-driven bench for next_address_control; each record is one microword
// occupying the pipeline for one cycle, with the slice controls expected in that cycle.
module tb_next_address_control;

  localparam logic [1:0] PC = 2'b00;
  localparam logic [1:0] AR = 2'b01;
  localparam logic [1:0] ST = 2'b10;
  localparam logic [1:0] DB = 2'b11;
  localparam logic [11:0] MAP  = 12'hA5C;
  localparam logic [11:0] VECT = 12'h3F0;

  typedef struct {
    logic [3:0]  uop;
    logic [11:0] uba;
    logic        pass;
    logic        hold;
    logic [1:0]  s;
    logic        fe, pup, re, zero, cin;
    logic [11:0] d;
    logic        cz, err;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  uop;
  logic [11:0] uba;
  logic [2:0]  cc_sel;
  logic        cc_pol;
  logic [7:0]  cc_vec;
  logic [11:0] map_addr;
  logic [11:0] vect_addr;
  logic        hold;
  logic        s1, s0, fe, pup, re, zero, cin, ctr_zero, stk_err;
  logic [11:0] d_out;

  int n_vec  = 0;
  int n_miss = 0;
  vec_t tbl[$];

  next_address_control #(.AW(12), .CW(12)) dut (
    .clock(clock), .reset_n(reset_n), .uop(uop), .uba(uba), .cc_sel(cc_sel),
    .cc_pol(cc_pol), .cc_vec(cc_vec), .map_addr(map_addr), .vect_addr(vect_addr),
    .hold(hold), .s1(s1), .s0(s0), .fe(fe), .pup(pup), .re(re), .zero(zero),
    .cin(cin), .d_out(d_out), .ctr_zero(ctr_zero), .stk_err(stk_err)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic [3:0] op, input logic [11:0] ba, input logic pass,
                              input logic hld, input logic [1:0] s, input logic efe,
                              input logic epup, input logic ere, input logic ezero,
                              input logic ecin, input logic [11:0] d, input logic cz,
                              input logic err);
    vec_t t;
    t.uop = op; t.uba = ba; t.pass = pass; t.hold = hld; t.s = s; t.fe = efe;
    t.pup = epup; t.re = ere; t.zero = ezero; t.cin = ecin; t.d = d; t.cz = cz; t.err = err;
    return t;
  endfunction

  // Packed order: s1 s0 fe pup re zero cin d_out[11:0] ctr_zero stk_err
  task automatic check(input string name, input vec_t t);
    logic [20:0] act;
    logic [20:0] exp;
    act = {s1, s0, fe, pup, re, zero, cin, d_out, ctr_zero, stk_err};
    exp = {t.s, t.fe, t.pup, t.re, t.zero, t.cin, t.d, t.cz, t.err};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got s=%b fe=%b pup=%b re=%b zero=%b cin=%b d=%h cz=%b err=%b, expected s=%b fe=%b pup=%b re=%b zero=%b cin=%b d=%h cz=%b err=%b",
               name, {s1, s0}, fe, pup, re, zero, cin, d_out, ctr_zero, stk_err,
               t.s, t.fe, t.pup, t.re, t.zero, t.cin, t.d, t.cz, t.err);
    end
  endtask

  // Microword goes in before the edge; live condition/hold follow the edge. The selected
  // bit carries the wanted result and every other bit carries the opposite value.
  task automatic run_vec(input vec_t t, input int idx, input string name);
    logic [7:0] one_hot;
    @(negedge clock);
    uop    = t.uop;
    uba    = t.uba;
    cc_sel = idx[2:0];
    cc_pol = idx[3];
    @(posedge clock);
    #1;
    hold    = t.hold;
    one_hot = 8'h01 << idx[2:0];
    cc_vec  = (t.pass ^ idx[3]) ? one_hot : ~one_hot;
    #1;
    check(name, t);
  endtask

  initial begin
    reset_n = 1'b0; uop = 4'd14; uba = 12'h000; cc_sel = 3'd0; cc_pol = 1'b0;
    cc_vec = 8'h00; map_addr = MAP; vect_addr = VECT; hold = 1'b0;

    tbl.push_back(mk(4'd14, 12'h123, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h123, 1'b1, 1'b0));
    tbl.push_back(mk(4'd2,  12'h111, 1'b0, 1'b0, DB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, MAP,     1'b1, 1'b0));
    tbl.push_back(mk(4'd3,  12'h200, 1'b1, 1'b0, DB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h200, 1'b1, 1'b0));
    tbl.push_back(mk(4'd3,  12'h201, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h201, 1'b1, 1'b0));
    tbl.push_back(mk(4'd6,  12'h000, 1'b1, 1'b0, DB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, VECT,    1'b1, 1'b0));
    tbl.push_back(mk(4'd6,  12'h00C, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h00C, 1'b1, 1'b0));
    tbl.push_back(mk(4'd7,  12'h055, 1'b0, 1'b0, AR, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h055, 1'b1, 1'b0));
    tbl.push_back(mk(4'd7,  12'h056, 1'b1, 1'b0, DB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h056, 1'b1, 1'b0));
    // LDCT 3 then RPCT: three D cycles, then PC
    tbl.push_back(mk(4'd12, 12'h003, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h003, 1'b1, 1'b0));
    tbl.push_back(mk(4'd9,  12'h040, 1'b0, 1'b0, DB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h040, 1'b0, 1'b0));
    tbl.push_back(mk(4'd9,  12'h040, 1'b1, 1'b0, DB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h040, 1'b0, 1'b0));
    tbl.push_back(mk(4'd9,  12'h040, 1'b0, 1'b0, DB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h040, 1'b0, 1'b0));
    tbl.push_back(mk(4'd9,  12'h040, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h040, 1'b1, 1'b0));
    // Subroutine call/return and the other stack ops
    tbl.push_back(mk(4'd1,  12'h300, 1'b1, 1'b0, DB, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h300, 1'b1, 1'b0));
    tbl.push_back(mk(4'd10, 12'h000, 1'b1, 1'b0, ST, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 1'b0));
    tbl.push_back(mk(4'd14, 12'h000, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 1'b0));
    tbl.push_back(mk(4'd1,  12'h301, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h301, 1'b1, 1'b0));
    tbl.push_back(mk(4'd10, 12'h002, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h002, 1'b1, 1'b0));
    tbl.push_back(mk(4'd5,  12'h0AA, 1'b0, 1'b0, AR, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0AA, 1'b1, 1'b0));
    tbl.push_back(mk(4'd5,  12'h0AB, 1'b1, 1'b0, DB, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0AB, 1'b1, 1'b0));
    tbl.push_back(mk(4'd11, 12'h0BB, 1'b1, 1'b0, DB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0BB, 1'b1, 1'b0));
    tbl.push_back(mk(4'd11, 12'h0BC, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0BC, 1'b1, 1'b0));
    tbl.push_back(mk(4'd13, 12'h0D0, 1'b0, 1'b0, ST, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0D0, 1'b1, 1'b0));
    tbl.push_back(mk(4'd13, 12'h0D0, 1'b1, 1'b0, PC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0D0, 1'b1, 1'b0));
    // PUSH loads 2, TWB failing: stack twice, then D with pop
    tbl.push_back(mk(4'd4,  12'h002, 1'b1, 1'b0, PC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h002, 1'b1, 1'b0));
    tbl.push_back(mk(4'd15, 12'h0C0, 1'b0, 1'b0, ST, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0C0, 1'b0, 1'b0));
    tbl.push_back(mk(4'd15, 12'h0C0, 1'b0, 1'b0, ST, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0C0, 1'b0, 1'b0));
    tbl.push_back(mk(4'd15, 12'h0C0, 1'b0, 1'b0, DB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0C0, 1'b1, 1'b0));
    // Same with TWB passing first time: PC with pop, counter keeps 2
    tbl.push_back(mk(4'd4,  12'h002, 1'b1, 1'b0, PC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h002, 1'b1, 1'b0));
    tbl.push_back(mk(4'd15, 12'h0C0, 1'b1, 1'b0, PC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h0C0, 1'b0, 1'b0));
    tbl.push_back(mk(4'd14, 12'h000, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0));
    tbl.push_back(mk(4'd4,  12'h007, 1'b0, 1'b0, PC, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h007, 1'b0, 1'b0));
    tbl.push_back(mk(4'd14, 12'h000, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0));
    tbl.push_back(mk(4'd8,  12'h000, 1'b0, 1'b0, ST, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0));
    tbl.push_back(mk(4'd8,  12'h000, 1'b0, 1'b0, ST, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0));
    tbl.push_back(mk(4'd8,  12'h000, 1'b0, 1'b0, PC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 1'b0));
    tbl.push_back(mk(4'd0,  12'h777, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h777, 1'b1, 1'b0));
    // JZ clears depth 1 -> 0, so only the fifth push after it overflows
    tbl.push_back(mk(4'd1,  12'h300, 1'b1, 1'b0, DB, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h300, 1'b1, 1'b0));
    tbl.push_back(mk(4'd0,  12'h000, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(4'd1, 12'h310, 1'b1, 1'b0, DB, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h310, 1'b1, 1'b0));
    tbl.push_back(mk(4'd14, 12'h000, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1));
    tbl.push_back(mk(4'd10, 12'h000, 1'b1, 1'b0, ST, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1));
    // PUSH loads 5, RFCT held for one cycle (next uop ignored), then five stack cycles
    tbl.push_back(mk(4'd4,  12'h005, 1'b1, 1'b0, PC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h005, 1'b1, 1'b1));
    tbl.push_back(mk(4'd8,  12'h000, 1'b0, 1'b1, PC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1));
    tbl.push_back(mk(4'd14, 12'h000, 1'b0, 1'b0, ST, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b1));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(4'd8, 12'h000, 1'b0, 1'b0, ST, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b1));
    tbl.push_back(mk(4'd8,  12'h000, 1'b0, 1'b0, PC, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1));

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("reset_release", mk(4'd0, 12'h000, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0));

    for (int i = 0; i < tbl.size(); i++)
      run_vec(tbl[i], i, $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of an RPCT loop
    run_vec(mk(4'd12, 12'h004, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h004, 1'b1, 1'b1), 3, "mid_ldct");
    run_vec(mk(4'd9,  12'h040, 1'b0, 1'b0, DB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h040, 1'b0, 1'b1), 5, "mid_rpct");
    uop = 4'd14;
    uba = 12'h000;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_reset", mk(4'd0, 12'h000, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0));
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("mid_release", mk(4'd0, 12'h000, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0));

    // Pop at depth 0: controls still issued, stk_err sets from the next edge
    run_vec(mk(4'd10, 12'h000, 1'b1, 1'b0, ST, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 1'b0), 6, "underflow_pop");
    run_vec(mk(4'd14, 12'h000, 1'b0, 1'b0, PC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1), 9, "underflow_flag");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/next_address_control.md
# next_address_control

Microprogram next-address controller: the instruction-decode end of the microsequencer interface, in the style of the Am29811. It pipelines the next-address fields of each microword and evaluates a selected test condition. It drives the select, stack, register-load, zero and carry controls (s1, s0, fe, pup, re, zero, cin) plus the D-bus address of the cascaded 4-bit sequencer slices. It also owns the loop counter and tracks the depth of the slices' 4-entry stack.

## Interface
- AW, 12, microaddress width (multiple of 4, one sequencer slice per nibble)
- CW, 12, loop counter width (CW ≤ AW)
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- uop  in  4  next-address opcode from microword ROM output
- uba  in  AW  branch/count field from microword ROM output
- cc_sel  in  3  condition select from ROM output
- cc_pol  in  1  1 = invert selected condition
- cc_vec  in  8  live condition inputs
- map_addr  in  AW  mapping PROM address
- vect_addr  in  AW  interrupt vector address
- hold  in  1  stall: freeze all state
- s1, s0  out  1 each  sequencer source: 00 PC, 01 AR, 10 stack, 11 D
- fe  out  1  stack enable, active-low
- pup  out  1  1 push, 0 pop (meaningful only when fe=0)
- re  out  1  AR load, active-low
- zero  out  1  active-low, forces sequencer address to 0
- cin  out  1  PC increment carry
- d_out  out  AW  sequencer D/R bus
- ctr_zero  out  1  loop counter equals 0
- stk_err  out  1  sticky stack overflow/underflow

## Operation
- The pipeline register holds {op, ba, sel, pol}. It loads from the uop/uba/cc_sel/cc_pol inputs each clock unless hold=1.
- PASS = cc_vec[sel] XOR pol, evaluated combinationally from the live cc_vec.
- Defaults: s=00, fe=1, pup=0, re=1, zero=1, cin=1, d_out=ba.
- Opcodes (fail / pass):
  - 0 JZ: zero=0; depth cleared.
  - 1 CJS: PC / D with push.
  - 2 JMAP: D, d_out=map_addr.
  - 3 CJP: PC / D.
  - 4 PUSH: push always; on pass, load counter.
  - 5 JSRP: AR with push / D with push.
  - 6 CJV: PC / D with d_out=vect_addr.
  - 7 JRP: AR / D.
  - 8 RFCT: counter≠0 → stack, decrement; counter=0 → PC with pop.
  - 9 RPCT: counter≠0 → D, decrement; counter=0 → PC.
  - 10 CRTN: PC / stack with pop.
  - 11 CJPP: PC / D with pop.
  - 12 LDCT: PC, load counter.
  - 13 LOOP: stack / PC with pop.
  - 14 CONT: PC.
  - 15 TWB: fail with counter≠0 → stack, decrement; fail with counter=0 → D with pop; pass → PC with pop.
- Push: fe=0, pup=1. Pop: fe=0, pup=0.
- Counter load: counter ← ba[CW-1:0]. re=0 at the same time, so the slices' AR captures d_out (rin is tied to d_out).
- Decrement: counter − 1, modulo 2^CW. It never occurs when counter=0.
- Depth tracker (0..4): push increments, pop decrements.
  - Push at depth 4 sets stk_err; depth stays 4.
  - Pop at depth 0 sets stk_err; depth stays 0.
  - Control outputs are issued regardless of depth.
- stk_err clears only on reset.
- hold=1 overrides all outputs to: s=00, fe=1, re=1, zero=1, cin=0. The sequencer re-emits its PC, so the fetch repeats. Counter, depth and pipeline are unchanged.

## Timing
- All control outputs are combinational from the pipeline register, the counter, PASS and hold. They are valid in the same cycle the sequencer uses them.
- Counter, depth, stk_err and pipeline update on the rising clock edge.
- The fetched microword's next-address opcode takes effect one cycle after its address is issued (one pipeline stage).
- Reset (asserted asynchronously, at any time including mid-loop):
  - pipeline op=JZ, ba=0, sel=0, pol=0
  - counter=0, depth=0, stk_err=0
  - First cycle after release: zero=0, fe=1, re=1, cin=1, s=00, d_out=0, ctr_zero=1.
- Counter load and decrement never coincide. A stack operation and a counter load can coincide (PUSH with pass).

## Test plan
- Reset released with uop=14 (CONT) streaming → cycle 1: zero=0, d_out=0. Thereafter: s=00, cin=1, zero=1.
- LDCT with uba=3, then RPCT with ba=0x040 → three cycles of s=11, d_out=0x040; counter 3→2→1→0; fourth cycle s=00; ctr_zero=1.
- CJS with pass, then CRTN with pass → s=11 with fe=0, pup=1 (depth 1); then s=10 with fe=0, pup=0 (depth 0); stk_err=0.
- Five consecutive CJS passes → fe=0, pup=1 on all five; depth saturates at 4; stk_err=1 from the edge after the fifth push.
- TWB with counter=2, condition failing → stack twice (counter 2→1→0); then s=11 with pop. Repeat with the condition passing on the first cycle → s=00 with pop; counter unchanged.
- hold=1 during RFCT with counter=5 → cin=0, s=00, fe=1; counter stays 5. After release, RFCT resumes with s=10 and decrements to 4.
